// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported, variable-latency RAM between the
// instruction-fetch port and the load/store port. Requests are sequenced
// one at a time with round-robin priority. Each completion produces a
// one-cycle done pulse with registered read data. A RAM that never answers
// locks the block into a terminal error state until reset.
module mem_arbiter #(
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  // fetch port
  input  logic              if_req_i,
  input  logic [DATA_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_done_o,
  // load/store port
  input  logic              mem_rd_i,
  input  logic              mem_wr_i,
  input  logic [DATA_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_done_o,
  // pipeline stalls
  output logic              fetch_stall_o,
  output logic              mem_stall_o,
  // RAM side
  output logic              ram_en_o,
  output logic              ram_wr_o,
  output logic [DATA_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i,
  input  logic              ram_ready_i,
  // status
  output logic              err_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2,
    ST_ERR  = 2'd3
  } state_e;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_e;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_e            state_q;
  gnt_e              gnt_q;
  gnt_e              last_grant_q;
  logic [3:0]        wait_cnt_q;
  logic              ram_en_q;
  logic              ram_wr_q;
  logic [DATA_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] mem_rdata_q;
  logic              if_done_q;
  logic              mem_done_q;
  logic              err_q;

  logic              i_pend_s;
  logic              d_pend_s;
  logic              grant_valid_d;
  gnt_e              grant_side_d;
  logic [3:0]        wait_cnt_d;
  logic              timeout_s;

  // Round-robin grant decision and wait-counter next value.
  always_comb begin
    i_pend_s      = if_req_i;
    d_pend_s      = mem_rd_i | mem_wr_i;
    grant_valid_d = i_pend_s | d_pend_s;
    grant_side_d  = GNT_I;
    if (i_pend_s && d_pend_s) begin
      // Both waiting: the side that did not win last time goes first.
      grant_side_d = (last_grant_q == GNT_I) ? GNT_D : GNT_I;
    end else if (d_pend_s) begin
      grant_side_d = GNT_D;
    end else begin
      grant_side_d = GNT_I;
    end
    wait_cnt_d = wait_cnt_q + 4'd1;
    timeout_s  = (wait_cnt_d == MAX_WAIT_C);
  end

  // Access sequencer: grant, wait for RAM, respond, or lock into error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      gnt_q        <= GNT_I;
      last_grant_q <= GNT_I;
      wait_cnt_q   <= 4'd0;
      ram_en_q     <= 1'b0;
      ram_wr_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
      if_done_q    <= 1'b0;
      mem_done_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // Done strobes are single-cycle; they are only raised on WAIT->RESP.
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      // Simultaneous load and store is a pipeline bug: flag it, sticky.
      if (mem_rd_i && mem_wr_i) begin
        err_q <= 1'b1;
      end else begin
        err_q <= err_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (grant_valid_d) begin
            gnt_q        <= grant_side_d;
            last_grant_q <= grant_side_d;
            wait_cnt_q   <= 4'd0;
            ram_en_q     <= 1'b1;
            state_q      <= ST_WAIT;
            if (grant_side_d == GNT_D) begin
              ram_addr_q  <= mem_addr_i;
              ram_wdata_q <= mem_wdata_i;
              // A conflicting rd+wr resolves to the store.
              ram_wr_q    <= mem_wr_i;
            end else begin
              ram_addr_q  <= if_addr_i;
              ram_wdata_q <= '0;
              ram_wr_q    <= 1'b0;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (ram_ready_i) begin
            ram_en_q <= 1'b0;
            state_q  <= ST_RESP;
            if (gnt_q == GNT_D) begin
              mem_done_q <= 1'b1;
              // Stores leave the load-data register untouched.
              if (!ram_wr_q) begin
                mem_rdata_q <= ram_rdata_i;
              end else begin
                mem_rdata_q <= mem_rdata_q;
              end
            end else begin
              if_done_q  <= 1'b1;
              if_rdata_q <= ram_rdata_i;
            end
          end else if (timeout_s) begin
            wait_cnt_q <= wait_cnt_d;
            ram_en_q   <= 1'b0;
            err_q      <= 1'b1;
            state_q    <= ST_ERR;
          end else begin
            wait_cnt_q <= wait_cnt_d;
            state_q    <= ST_WAIT;
          end
        end
        ST_RESP: begin
          // Forced idle cycle before the next grant.
          state_q <= ST_IDLE;
        end
        ST_ERR: begin
          ram_en_q <= 1'b0;
          err_q    <= 1'b1;
          state_q  <= ST_ERR;
        end
        default: begin
          ram_en_q <= 1'b0;
          err_q    <= 1'b1;
          state_q  <= ST_ERR;
        end
      endcase
    end
  end

  // Stalls must act in the same cycle as the request, so they combine the
  // live request with the registered done strobe; ERR freezes the pipeline.
  assign fetch_stall_o = (state_q == ST_ERR) | (if_req_i & ~if_done_q);
  assign mem_stall_o   = (state_q == ST_ERR) | ((mem_rd_i | mem_wr_i) & ~mem_done_q);

  assign ram_en_o    = ram_en_q;
  assign ram_wr_o    = ram_wr_q;
  assign ram_addr_o  = ram_addr_q;
  assign ram_wdata_o = ram_wdata_q;
  assign if_rdata_o  = if_rdata_q;
  assign mem_rdata_o = mem_rdata_q;
  assign if_done_o   = if_done_q;
  assign mem_done_o  = mem_done_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of single-port transactions
// plus hand-written sequences for arbitration, timeout, async reset,
// conflicting load/store and a dropped request.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [15:0] if_addr;
  logic [15:0] if_rdata;
  logic        if_done;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_done;
  logic        fetch_stall;
  logic        mem_stall;
  logic        ram_en;
  logic        ram_wr;
  logic [15:0] ram_addr;
  logic [15:0] ram_wdata;
  logic [15:0] ram_rdata;
  logic        ram_ready;
  logic        err;

  int n_cmp;
  int n_err;

  // RAM model: ready after 'lat' cycles of ram_en, if enabled.
  int          lat;
  logic        ready_en;
  logic [15:0] rdata_val;
  int          en_cnt;

  mem_arbiter #(.DATA_W(16), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_rdata_o(if_rdata), .if_done_o(if_done),
    .mem_rd_i(mem_rd), .mem_wr_i(mem_wr), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
    .mem_rdata_o(mem_rdata), .mem_done_o(mem_done),
    .fetch_stall_o(fetch_stall), .mem_stall_o(mem_stall),
    .ram_en_o(ram_en), .ram_wr_o(ram_wr), .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
    .ram_rdata_i(ram_rdata), .ram_ready_i(ram_ready),
    .err_o(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst || !ram_en) en_cnt <= 0;
    else                en_cnt <= en_cnt + 1;
  end
  assign ram_ready = ram_en & ready_en & (en_cnt == lat - 1);
  assign ram_rdata = rdata_val;

  typedef struct {
    logic        is_fetch;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] rdata;
    int          exp_done;
    logic [15:0] exp_if_rdata;
    logic [15:0] exp_mem_rdata;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = 16'h0000;
    mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = 16'h0000; mem_wdata = 16'h0000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    ready_en = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic run_row(input int idx, input vec_t v);
    int   done_cyc;
    int   en_cyc;
    logic bus_ok;
    logic stall_ok;
    logic other_done;
    logic pd;
    logic od;
    logic st;
    rdata_val = v.rdata; lat = v.lat; ready_en = 1'b1;
    if (v.is_fetch) begin
      if_req = 1'b1; if_addr = v.addr;
    end else begin
      mem_rd = ~v.wr; mem_wr = v.wr; mem_addr = v.addr; mem_wdata = v.wdata;
    end
    done_cyc = -1; en_cyc = 0; bus_ok = 1'b1; stall_ok = 1'b1; other_done = 1'b0;
    for (int c = 1; c <= 30 && done_cyc < 0; c++) begin
      tick();
      if (ram_en) begin
        en_cyc++;
        if (ram_addr !== v.addr || ram_wr !== v.wr || (v.wr && ram_wdata !== v.wdata)) bus_ok = 1'b0;
      end
      pd = v.is_fetch ? if_done : mem_done;
      od = v.is_fetch ? mem_done : if_done;
      st = v.is_fetch ? fetch_stall : mem_stall;
      if (od) other_done = 1'b1;
      if (pd) begin
        done_cyc = c;
        if (st !== 1'b0) stall_ok = 1'b0;
      end else if (st !== 1'b1) begin
        stall_ok = 1'b0;
      end
    end
    $display("row %0d: done at cycle %0d, ram_en cycles %0d", idx, done_cyc, en_cyc);
    chk("row_done_cycle", done_cyc, v.exp_done);
    chk("row_ram_en_cycles", en_cyc, v.lat);
    chk("row_ram_bus", bus_ok, 1'b1);
    chk("row_stall", stall_ok, 1'b1);
    chk("row_other_done", other_done, 1'b0);
    chk("row_if_rdata", if_rdata, v.exp_if_rdata);
    chk("row_mem_rdata", mem_rdata, v.exp_mem_rdata);
    chk("row_err", err, 1'b0);
    clear_inputs();
    tick();
    pd = v.is_fetch ? if_done : mem_done;
    chk("row_done_width", pd, 1'b0);
  endtask

  initial begin
    int   addrs[4];
    int   cycs[4];
    int   n_acc;
    logic prev_en;
    logic first_mem;
    logic seen_done;
    int   en_cyc;
    int   done_cyc;
    logic wr_ok;

    n_cmp = 0; n_err = 0;
    lat = 1; ready_en = 1'b1; rdata_val = 16'h0000;
    rst = 1'b1;
    clear_inputs();

    vecs[0] = '{1'b1, 1'b0, 16'h0040, 16'h0000, 1, 16'hA5A5, 2, 16'hA5A5, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 16'h1000, 16'hBEEF, 3, 16'h9999, 4, 16'hA5A5, 16'h0000};
    vecs[2] = '{1'b0, 1'b0, 16'h2000, 16'h0000, 2, 16'h1234, 3, 16'hA5A5, 16'h1234};
    vecs[3] = '{1'b0, 1'b1, 16'h3000, 16'hCAFE, 1, 16'h5555, 2, 16'hA5A5, 16'h1234};
    vecs[4] = '{1'b1, 1'b0, 16'h0042, 16'h0000, 4, 16'h7777, 5, 16'h7777, 16'h1234};

    // Reset state
    tick();
    chk("rst_ram_en", ram_en, 1'b0);
    chk("rst_ram_wr", ram_wr, 1'b0);
    chk("rst_ram_addr", ram_addr, 16'h0000);
    chk("rst_ram_wdata", ram_wdata, 16'h0000);
    chk("rst_done", {if_done, mem_done}, 2'b00);
    chk("rst_rdata", {if_rdata, mem_rdata}, 32'h0000_0000);
    chk("rst_err", err, 1'b0);
    chk("rst_stalls", {fetch_stall, mem_stall}, 2'b00);
    tick();
    rst = 1'b0;

    // Table of single-port transactions
    for (int i = 0; i < 5; i++) run_row(i, vecs[i]);

    // Both ports pending from reset: D first, then alternation
    rst = 1'b1;
    clear_inputs();
    lat = 1; ready_en = 1'b1; rdata_val = 16'h3C3C;
    if_req = 1'b1; if_addr = 16'h0100;
    mem_rd = 1'b1; mem_addr = 16'h0200;
    repeat (2) tick();
    rst = 1'b0;
    n_acc = 0; prev_en = 1'b0; first_mem = 1'b0; seen_done = 1'b0;
    for (int c = 1; c <= 40 && n_acc < 4; c++) begin
      tick();
      if (ram_en && !prev_en) begin
        addrs[n_acc] = int'(ram_addr);
        cycs[n_acc]  = c;
        n_acc++;
      end
      if (!seen_done && (mem_done || if_done)) begin
        seen_done = 1'b1;
        first_mem = mem_done;
      end
      prev_en = ram_en;
    end
    chk("rr_count", n_acc, 4);
    chk("rr_first_done_mem", first_mem, 1'b1);
    chk("rr_addr0", addrs[0], 32'h0200);
    chk("rr_addr1", addrs[1], 32'h0100);
    chk("rr_addr2", addrs[2], 32'h0200);
    chk("rr_addr3", addrs[3], 32'h0100);
    chk("rr_gap01", cycs[1] - cycs[0], 3);
    chk("rr_gap12", cycs[2] - cycs[1], 3);

    // RAM never ready: timeout into ERR
    do_reset();
    ready_en = 1'b0;
    if_req = 1'b1; if_addr = 16'h0500;
    en_cyc = 0; seen_done = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (ram_en) en_cyc++;
      if (if_done || mem_done) seen_done = 1'b1;
    end
    chk("to_en_cycles", en_cyc, 15);
    chk("to_err", err, 1'b1);
    chk("to_ram_en", ram_en, 1'b0);
    chk("to_stalls", {fetch_stall, mem_stall}, 2'b11);
    chk("to_no_done", seen_done, 1'b0);
    if_req = 1'b0;
    repeat (3) tick();
    chk("to_stalls_stuck", {fetch_stall, mem_stall, err}, 3'b111);

    // Async reset in the middle of WAIT
    do_reset();
    ready_en = 1'b0;
    mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 16'h0900;
    repeat (3) tick();
    chk("ar_pre", {ram_en, err}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    chk("ar_drop", {ram_en, err}, 2'b00);
    clear_inputs();
    tick();
    rst = 1'b0;
    ready_en = 1'b1; lat = 1; rdata_val = 16'h0F0F;
    if_req = 1'b1; if_addr = 16'h0060;
    done_cyc = -1;
    for (int c = 1; c <= 10 && done_cyc < 0; c++) begin
      tick();
      if (if_done) done_cyc = c;
    end
    chk("ar_done_cycle", done_cyc, 2);
    chk("ar_rdata", if_rdata, 16'h0F0F);
    chk("ar_err", err, 1'b0);
    clear_inputs();
    tick();

    // Load and store together: the store happens, err set, done pulses
    do_reset();
    lat = 2; rdata_val = 16'hEEEE;
    mem_rd = 1'b1; mem_wr = 1'b1; mem_addr = 16'h0800; mem_wdata = 16'h1357;
    done_cyc = -1; wr_ok = 1'b1;
    for (int c = 1; c <= 10 && done_cyc < 0; c++) begin
      tick();
      if (ram_en && (ram_wr !== 1'b1 || ram_wdata !== 16'h1357 || ram_addr !== 16'h0800)) wr_ok = 1'b0;
      if (mem_done) done_cyc = c;
    end
    chk("rw_done_cycle", done_cyc, 3);
    chk("rw_store_bus", wr_ok, 1'b1);
    chk("rw_err", err, 1'b1);
    chk("rw_mem_rdata", mem_rdata, 16'h0000);
    clear_inputs();
    tick();

    // Fetch dropped after one WAIT cycle still completes
    do_reset();
    lat = 3; rdata_val = 16'h4242;
    if_req = 1'b1; if_addr = 16'h0070;
    tick();
    if_req = 1'b0;
    done_cyc = -1;
    for (int c = 2; c <= 10 && done_cyc < 0; c++) begin
      tick();
      if (if_done) done_cyc = c;
    end
    chk("drop_done_cycle", done_cyc, 4);
    chk("drop_rdata", if_rdata, 16'h4242);
    chk("drop_stall", fetch_stall, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
